// File: rtl/mod_exp_ctrl.sv
// mod_exp_ctrl: left-to-right binary modular exponentiation controller.
// Computes x^e mod m by driving an external Montgomery multiplier
// (result = a*b*R^-1 mod m, R = 2^1024). The sequence is:
//   convert x into Montgomery form,
//   square, then multiply for each exponent bit from t down to 0,
//   convert back with a final multiply by 1.
// Optional build macro MOD_EXP_CONST_TIME_EN: every exponent bit issues
// both a square and a multiply. The multiply result is kept only when the
// bit is set, so the multiplier request pattern does not depend on e.
module mod_exp_ctrl (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  input  logic [1023:0] in_x,
  input  logic [1023:0] in_r,
  input  logic [1023:0] in_r2,
  input  logic [1023:0] in_m,
  input  logic [1023:0] in_e,
  input  logic [9:0]    in_t,
  output logic [1023:0] result,
  output logic          done,
  output logic          busy,
  output logic          mul_start,
  output logic [1023:0] mul_a,
  output logic [1023:0] mul_b,
  output logic [1023:0] mul_m,
  input  logic          mul_done,
  input  logic [1023:0] mul_result
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CONV  = 3'd1;
  localparam logic [2:0] S_SQR   = 3'd2;
  localparam logic [2:0] S_MUL   = 3'd3;
  localparam logic [2:0] S_STEP  = 3'd4;
  localparam logic [2:0] S_FINAL = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  localparam logic [1023:0] ONE = 1024'd1;

  logic [2:0]    state_q, state_d;
  logic [1023:0] x_q, x_d;
  logic [1023:0] r2_q, r2_d;
  logic [1023:0] m_q, m_d;
  logic [1023:0] e_q, e_d;
  logic [1023:0] a_q, a_d;
  logic [1023:0] xt_q, xt_d;
  logic [1023:0] result_q, result_d;
  logic [9:0]    i_q, i_d;
  // Set once the request for the current multiply state has been issued.
  logic          issued_q, issued_d;

  logic mul_state;
  logic accept;
  logic e_bit;

  // Multiply states request once on entry and accept a completion only
  // while their own request is outstanding.
  always_comb begin
    mul_state = (state_q == S_CONV) || (state_q == S_SQR) ||
                (state_q == S_MUL)  || (state_q == S_FINAL);
    mul_start = mul_state && !issued_q;
    accept    = mul_state && issued_q && mul_done;
    e_bit     = e_q[i_q];
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    result    = result_q;
  end

  // Operand routing; operands come from registers that only change when
  // the pending multiply completes, so they stay stable while it runs.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    mul_m = m_q;
    case (state_q)
      S_CONV:  begin mul_a = x_q; mul_b = r2_q; end
      S_SQR:   begin mul_a = a_q; mul_b = a_q;  end
      S_MUL:   begin mul_a = a_q; mul_b = xt_q; end
      S_FINAL: begin mul_a = a_q; mul_b = ONE;  end
      default: begin mul_a = '0;  mul_b = '0;   end
    endcase
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    r2_d     = r2_q;
    m_d      = m_q;
    e_d      = e_q;
    a_d      = a_q;
    xt_d     = xt_q;
    result_d = result_q;
    i_d      = i_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          x_d     = in_x;
          r2_d    = in_r2;
          m_d     = in_m;
          e_d     = in_e;
          i_d     = in_t;
          a_d     = in_r;
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        if (accept) begin
          xt_d    = mul_result;
          state_d = S_SQR;
        end
      end
      S_SQR: begin
        if (accept) begin
          a_d = mul_result;
`ifdef MOD_EXP_CONST_TIME_EN
          state_d = S_MUL;
`else
          state_d = e_bit ? S_MUL : S_STEP;
`endif
        end
      end
      S_MUL: begin
        if (accept) begin
`ifdef MOD_EXP_CONST_TIME_EN
          if (e_bit) begin
            a_d = mul_result;
          end
`else
          a_d = mul_result;
`endif
          state_d = S_STEP;
        end
      end
      S_STEP: begin
        // The counter stops at zero; bit 0 is the last one processed.
        if (i_q != 10'd0) begin
          i_d     = i_q - 10'd1;
          state_d = S_SQR;
        end else begin
          state_d = S_FINAL;
        end
      end
      S_FINAL: begin
        if (accept) begin
          result_d = mul_result;
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A new state always begins with no request issued.
    if (state_d != state_q) begin
      issued_d = 1'b0;
    end else if (mul_start) begin
      issued_d = 1'b1;
    end else begin
      issued_d = issued_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      x_q      <= '0;
      r2_q     <= '0;
      m_q      <= '0;
      e_q      <= '0;
      a_q      <= '0;
      xt_q     <= '0;
      result_q <= '0;
      i_q      <= '0;
      issued_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      r2_q     <= r2_d;
      m_q      <= m_d;
      e_q      <= e_d;
      a_q      <= a_d;
      xt_q     <= xt_d;
      result_q <= result_d;
      i_q      <= i_d;
      issued_q <= issued_d;
    end
  end

endmodule
